// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// mem_access_ctrl -- Y86-64 memory-stage controller: decodes the instruction,
//   range-checks the address and sequences a single-cycle read/write strobe.
// Revision: 1.0
// ============================================================================
module mem_access_ctrl #(
    parameter int MEM_WORDS = 512
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic        [3:0]  icode,
    input  logic signed [63:0] valE,
    input  logic signed [63:0] valA,
    input  logic signed [63:0] valP,
    input  logic signed [63:0] mem_rdata,
    input  logic               mem_err_in,
    output logic signed [63:0] mem_address,
    output logic signed [63:0] mem_data,
    output logic               read_enable,
    output logic               write_enable,
    output logic signed [63:0] valM,
    output logic               busy,
    output logic               done,
    output logic               dmem_error,
    output logic        [15:0] access_cnt
);

    localparam logic signed [63:0] MAX_ADDR = 64'(MEM_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t             state_q;
    logic               write_q;
    logic               read_enable_q;
    logic               write_enable_q;
    logic               busy_q;
    logic               done_q;
    logic               dmem_error_q;
    logic signed [63:0] mem_address_q;
    logic signed [63:0] mem_data_q;
    logic signed [63:0] valM_q;
    logic        [15:0] access_cnt_q;

    logic               req_mem;
    logic               req_write;
    logic               req_legal;
    logic signed [63:0] req_addr;
    logic signed [63:0] req_data;

    always_comb begin
        req_mem   = 1'b1;
        req_write = 1'b0;
        req_addr  = valE;
        req_data  = valA;
        case (icode)
            4'h4, 4'hA: req_write = 1'b1;
            4'h5:       req_write = 1'b0;
            4'h8: begin
                req_write = 1'b1;
                req_data  = valP;
            end
            4'h9, 4'hB: req_addr = valA;
            default:    req_mem = 1'b0;
        endcase
    end

    // Signed range check: bit 63 set means a negative address.
    assign req_legal = !req_addr[63] && (req_addr <= MAX_ADDR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            write_q        <= 1'b0;
            read_enable_q  <= 1'b0;
            write_enable_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            dmem_error_q   <= 1'b0;
            mem_address_q  <= '0;
            mem_data_q     <= '0;
            valM_q         <= '0;
            access_cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        busy_q       <= 1'b1;
                        dmem_error_q <= 1'b0;
                        if (req_mem && req_legal) begin
                            state_q       <= SETUP;
                            mem_address_q <= req_addr;
                            mem_data_q    <= req_data;
                            write_q       <= req_write;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            if (req_mem) begin
                                dmem_error_q <= 1'b1;
                                valM_q       <= '0;
                            end
                        end
                    end
                end
                SETUP: begin
                    state_q        <= ACCESS;
                    read_enable_q  <= !write_q;
                    write_enable_q <= write_q;
                end
                ACCESS: begin
                    state_q        <= DONE;
                    done_q         <= 1'b1;
                    read_enable_q  <= 1'b0;
                    write_enable_q <= 1'b0;
                    access_cnt_q   <= access_cnt_q + 16'd1;
                    if (read_enable_q) begin
                        valM_q <= mem_rdata;
                    end
                    if (mem_err_in) begin
                        dmem_error_q <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_address  = mem_address_q;
    assign mem_data     = mem_data_q;
    assign read_enable  = read_enable_q;
    assign write_enable = write_enable_q;
    assign valM         = valM_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign dmem_error   = dmem_error_q;
    assign access_cnt   = access_cnt_q;

endmodule
`default_nettype wire

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have exactly one clock, clk; all state updates on its rising edge.
REQ-002 SHALL have reset rst, asynchronous and active-high.
REQ-003 Port list (name  direction  width  meaning):
- clk  in  1  clock
- rst  in  1  async active-high reset
- start  in  1  one-cycle request pulse from the memory stage
- icode  in  4  Y86-64 instruction code
- valE  in  64 signed  ALU result
- valA  in  64 signed  register A value
- valP  in  64 signed  next-PC value
- mem_rdata  in  64 signed  read data returned by the data memory
- mem_err_in  in  1  data-memory error flag
- mem_address  out  64 signed  address to the data memory
- mem_data  out  64 signed  write data to the data memory
- read_enable  out  1  memory read strobe
- write_enable  out  1  memory write strobe
- valM  out  64 signed  captured read result
- busy  out  1  access in progress
- done  out  1  one-cycle completion pulse
- dmem_error  out  1  access error for the last request
- access_cnt  out  16  count of completed memory accesses
REQ-004 Parameter MEM_WORDS, default 512, number of addressable 64-bit words.

Function
REQ-005 Address/data/direction latched on the start cycle:
- rmmovq (4): write valA at valE
- mrmovq (5): read at valE
- call (8): write valP at valE
- ret (9): read at valA
- pushq (A): write valA at valE
- popq (B): read at valA
- any other icode: no access
REQ-006 FSM states IDLE, SETUP, ACCESS, DONE.
REQ-007 IDLE: start=1 with a memory icode and a legal address -> SETUP; start=1 with a non-memory icode or an illegal address -> DONE; otherwise stay in IDLE.
REQ-008 An address is legal only if 0 <= address <= MEM_WORDS-1, compared as a signed value, so negative addresses are illegal.
REQ-009 SETUP: mem_address and mem_data driven from the latched values, both strobes 0; next state ACCESS.
REQ-010 ACCESS: exactly one strobe is 1 for exactly one cycle. Reads capture mem_rdata into valM at the end of the cycle. mem_err_in sampled at the end of the cycle and ORed into dmem_error. Next state DONE.
REQ-011 DONE: done=1 for one cycle, strobes 0; next state IDLE.
REQ-012 read_enable and write_enable are never both 1, and both are 0 outside ACCESS.
REQ-013 busy=1 in SETUP, ACCESS and DONE.
REQ-014 start while busy=1 is ignored, with no effect on state, latched values or outputs.
REQ-015 Latency: start sampled at edge N gives done=1 during cycle N+3 for a legal access, and during cycle N+1 for a non-memory icode or an illegal address.
REQ-016 valM update rules:
- reads: set to the captured data
- writes and non-memory icodes: valM holds its previous value
- illegal address: valM cleared to 0
REQ-017 dmem_error is cleared on each accepted start, set to 1 for an illegal address (no strobe issued) or a sampled mem_err_in, and held until the next accepted start.
REQ-018 access_cnt increments by 1 on each ACCESS cycle and wraps from 0xFFFF to 0x0000.
REQ-019 mem_address and mem_data hold their values from SETUP through DONE.

Reset
REQ-020 While rst=1, asynchronously and regardless of state, all of the following hold:
- FSM state = IDLE
- read_enable, write_enable, busy, done, dmem_error = 0
- valM, mem_address, mem_data = 0
- access_cnt = 0
REQ-021 Reset asserted mid-access drops the strobe in the same cycle and aborts the access without a done pulse; the first start after reset deassertion is accepted normally.

Verification
REQ-022 Write path: icode=4, valA=0x1234, valE=10 -> write_enable=1 for one cycle at N+2 with mem_address=10, mem_data=0x1234; done at N+3; dmem_error=0; access_cnt=1.
REQ-023 Read path: icode=5, valE=10, mem_rdata=0x1234 -> read_enable=1 at N+2; done at N+3; valM=0x1234.
REQ-024 Address errors:
- icode=B, valA=-8 -> no strobe; done at N+1; dmem_error=1; valM=0
- icode=A, valE=512 -> same response
REQ-025 Ignored and short requests:
- icode=6 -> done at N+1, no strobe, access_cnt unchanged
- start pulsed during SETUP -> ignored
REQ-026 Reset and wrap:
- rst asserted during ACCESS -> strobe falls immediately, no done pulse, all outputs 0
- access_cnt preloaded to 0xFFFF by 65535 accesses, then one more access -> 0x0000
